// File: rtl/spi_pkg.sv
// State encoding and frame timing constants shared by the SPI MOSI scheduler.
package spi_pkg;

   localparam int SPI_DSIZE       = 8;
   localparam int SETUP_CYCLES    = 1;
   // HOLD spans two edges: one drives MOSI back to 0, the next raises spi_cs.
   localparam int HOLD_CYCLES     = 2;
   localparam int FRAME_CS_CYCLES = SETUP_CYCLES + 2 * SPI_DSIZE + HOLD_CYCLES - 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_ADDR,
      S_DATA,
      S_HOLD,
      S_GAP
   } spi_state_e;

   function automatic int rr_slot(input int base, input int off, input int n);
      return (base + off) % n;
   endfunction

endpackage

// File: rtl/spi_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or above ptr, wrapping.
module spi_rr_arbiter
   import spi_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int PW   = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [PW-1:0]   ptr,
   output logic [NREQ-1:0] pick,
   output logic [PW-1:0]   pick_idx
);

   logic          found;
   logic [PW-1:0] slot;

   always_comb begin
      pick     = '0;
      pick_idx = '0;
      found    = 1'b0;
      slot     = '0;
      for (int i = 0; i < NREQ; i++) begin
         slot = PW'(rr_slot(int'(ptr), i, NREQ));
         if (!found && req[slot]) begin
            found       = 1'b1;
            pick[slot]  = 1'b1;
            pick_idx    = slot;
         end
      end
   end

endmodule

// File: rtl/spi_mosi_arbiter.sv
// Shares one SPI MOSI output between NREQ requesters: round-robin grant, then
// an LSB-first address byte followed by a data byte under a low spi_cs.
module spi_mosi_arbiter
   import spi_pkg::*;
#(
   parameter int DSIZE      = SPI_DSIZE,
   parameter int NREQ       = 4,
   parameter int GAP_CYCLES = 2
) (
   input  logic                  spi_clk,
   input  logic                  n_reset,
   input  logic [NREQ-1:0]       req,
   input  logic [NREQ*DSIZE-1:0] req_add,
   input  logic [NREQ*DSIZE-1:0] req_data,
   output logic [NREQ-1:0]       grant,
   output logic [NREQ-1:0]       done,
   output logic                  spi_cs,
   output logic                  spi_mosi_out,
   output logic                  busy
);

   localparam int PW = $clog2(NREQ);
   localparam int BW = $clog2(DSIZE);
   localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

   logic [NREQ-1:0][DSIZE-1:0] add_lane;
   logic [NREQ-1:0][DSIZE-1:0] data_lane;

   for (genvar i = 0; i < NREQ; i++) begin : g_lane
      assign add_lane[i]  = req_add[i*DSIZE +: DSIZE];
      assign data_lane[i] = req_data[i*DSIZE +: DSIZE];
   end

   spi_state_e       state;
   logic [PW-1:0]    ptr;
   logic [PW-1:0]    win_q;
   logic [NREQ-1:0]  pick;
   logic [PW-1:0]    pick_idx;
   logic [DSIZE-1:0] add_q;
   logic [DSIZE-1:0] data_q;
   logic [BW-1:0]    bit_cnt;
   logic [GW-1:0]    gap_cnt;

   spi_rr_arbiter #(
      .NREQ (NREQ),
      .PW   (PW)
   ) u_rr (
      .req      (req),
      .ptr      (ptr),
      .pick     (pick),
      .pick_idx (pick_idx)
   );

   always_ff @(posedge spi_clk or negedge n_reset) begin
      if (!n_reset) begin
         state        <= S_IDLE;
         ptr          <= '0;
         win_q        <= '0;
         add_q        <= '0;
         data_q       <= '0;
         bit_cnt      <= '0;
         gap_cnt      <= '0;
         grant        <= '0;
         done         <= '0;
         spi_cs       <= 1'b1;
         spi_mosi_out <= 1'b0;
         busy         <= 1'b0;
      end else begin
         grant <= '0;
         done  <= '0;
         unique case (state)
            S_IDLE: begin
               spi_mosi_out <= 1'b0;
               if (|req) begin
                  grant   <= pick;
                  win_q   <= pick_idx;
                  add_q   <= add_lane[pick_idx];
                  data_q  <= data_lane[pick_idx];
                  bit_cnt <= '0;
                  spi_cs  <= 1'b0;
                  busy    <= 1'b1;
                  state   <= S_SETUP;
               end
            end
            S_SETUP: begin
               spi_mosi_out <= add_q[bit_cnt];
               bit_cnt      <= bit_cnt + 1'b1;
               state        <= S_ADDR;
            end
            S_ADDR: begin
               spi_mosi_out <= add_q[bit_cnt];
               bit_cnt      <= bit_cnt + 1'b1;
               if (bit_cnt == BW'(DSIZE - 1)) begin
                  bit_cnt <= '0;
                  state   <= S_DATA;
               end
            end
            S_DATA: begin
               spi_mosi_out <= data_q[bit_cnt];
               bit_cnt      <= bit_cnt + 1'b1;
               if (bit_cnt == BW'(DSIZE - 1)) begin
                  bit_cnt <= '0;
                  state   <= S_HOLD;
               end
            end
            S_HOLD: begin
               spi_mosi_out <= 1'b0;
               if (bit_cnt == BW'(HOLD_CYCLES - 1)) begin
                  bit_cnt <= '0;
                  spi_cs  <= 1'b1;
                  done    <= NREQ'(1) << win_q;
                  ptr     <= (win_q == PW'(NREQ - 1)) ? '0 : win_q + 1'b1;
                  gap_cnt <= '0;
                  // The IDLE cycle is the last high cycle of the gap, so GAP
                  // itself only covers GAP_CYCLES-1 cycles.
                  if (GAP_CYCLES > 1) begin
                     state <= S_GAP;
                  end else begin
                     state <= S_IDLE;
                     busy  <= 1'b0;
                  end
               end else begin
                  bit_cnt <= bit_cnt + 1'b1;
               end
            end
            S_GAP: begin
               if (int'(gap_cnt) == GAP_CYCLES - 2) begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
               end else begin
                  gap_cnt <= gap_cnt + 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
